// File: rtl/hazard_interlock_if.sv
// ID-stage hazard bundle: decoded source/write flags in, stall, forward selects and stall count out.
interface hazard_interlock_if #(
  parameter int CNT_W = 16
) ();
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_r1_used;
  logic             id_r2_used;
  logic             id_hi_used;
  logic             id_lo_used;
  logic             id_regwrite;
  logic [4:0]       id_dst;
  logic             id_memtoreg;
  logic             id_hiwrite;
  logic             id_lowrite;
  logic             stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt,
           id_r1_used, id_r2_used, id_hi_used, id_lo_used,
           id_regwrite, id_dst, id_memtoreg, id_hiwrite, id_lowrite,
    input  stall, fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt,
           id_r1_used, id_r2_used, id_hi_used, id_lo_used,
           id_regwrite, id_dst, id_memtoreg, id_hiwrite, id_lowrite,
    output stall, fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/hazard_interlock.sv
// Tracks EX/MEM/WB write footprints and derives the ID stall, EX operand forward
// selects and a saturating stall-cycle counter for the 5-stage MIPS pipeline.
module hazard_interlock #(
  parameter int FORWARD = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_interlock_if.slave  bus
);

  typedef struct packed {
    logic       v;
    logic       regwrite;
    logic [4:0] dst;
    logic       memtoreg;
    logic       hiwrite;
    logic       lowrite;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ex_prod, mem_prod;
  logic [4:0]       src     [2];
  logic [1:0]       src_used;
  logic [1:0]       m_ex, m_mem;
  logic [1:0]       fwd_sel [2];
  logic             gpr_haz, hilo_haz, stall, issue;

  // The regfile bypasses WB writes internally, so the WB slot never feeds hazards.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_q, mem_q.memtoreg};

  assign ex_prod  = ex_q.v  & ex_q.regwrite  & (ex_q.dst  != 5'd0);
  assign mem_prod = mem_q.v & mem_q.regwrite & (mem_q.dst != 5'd0);

  assign src[0]      = bus.id_rs;
  assign src[1]      = bus.id_rt;
  assign src_used[0] = bus.id_r1_used;
  assign src_used[1] = bus.id_r2_used;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign m_ex[gi]  = bus.id_valid & src_used[gi] & (src[gi] != 5'd0) &
                         ex_prod & (ex_q.dst == src[gi]);
      assign m_mem[gi] = bus.id_valid & src_used[gi] & (src[gi] != 5'd0) &
                         mem_prod & (mem_q.dst == src[gi]);
      // Youngest producer wins: EX/MEM result beats MEM/WB result.
      assign fwd_sel[gi] = m_ex[gi] ? 2'd1 : (m_mem[gi] ? 2'd2 : 2'd0);
    end
  endgenerate

  assign gpr_haz  = (FORWARD != 0) ? ((|m_ex) & ex_q.memtoreg) : ((|m_ex) | (|m_mem));
  assign hilo_haz = (bus.id_hi_used & ((ex_q.v & ex_q.hiwrite) | (mem_q.v & mem_q.hiwrite))) |
                    (bus.id_lo_used & ((ex_q.v & ex_q.lowrite) | (mem_q.v & mem_q.lowrite)));
  assign stall    = bus.id_valid & ~bus.flush & (gpr_haz | hilo_haz);
  assign issue    = bus.id_valid & ~bus.flush & ~stall;

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (!bus.hold) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '{v:        issue,
                regwrite: bus.id_regwrite,
                dst:      bus.id_dst,
                memtoreg: bus.id_memtoreg,
                hiwrite:  bus.id_hiwrite,
                lowrite:  bus.id_lowrite};
      fwd_a_d = ((FORWARD != 0) && issue) ? fwd_sel[0] : 2'd0;
      fwd_b_d = ((FORWARD != 0) && issue) ? fwd_sel[1] : 2'd0;
      if (stall && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.fwd_a        = fwd_a_q;
  assign bus.fwd_b        = fwd_b_q;
  assign bus.stall_cycles = cnt_q;

endmodule
